// File: rtl/cpu_defs_pkg.sv
// Shared MIPS32-subset definitions: opcodes, functs, ALU ops, fetch redirect types, ID/EX payload.
package cpu_defs_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NREGS   = 32;
  localparam int unsigned ALUOP_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_PASSA = 4'd7,
    ALU_PASSB = 4'd8
  } aluop_e;

  typedef enum logic [1:0] {
    PC_BRANCH = 2'b00,
    PC_REG    = 2'b01,
    PC_JUMP   = 2'b10,
    PC_EXCEPT = 2'b11
  } selpctype_e;

  typedef struct packed {
    logic [XLEN-1:0]    rega;
    logic [XLEN-1:0]    regb;
    logic [XLEN-1:0]    imedext;
    logic [XLEN-1:0]    nextpc;
    logic [ALUOP_W-1:0] aluop;
    logic [REG_AW-1:0]  regdest;
    logic               writereg;
    logic               memread;
    logic               memwrite;
    logic               selalusrc;
  } id_ex_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] x);
    return {{16{x[15]}}, x};
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, 2 read / 1 write; $0 hardwired to zero.
// DECODE_WB_BYPASS_EN forwards the same-cycle write data to the read ports.
module regfile
  import cpu_defs_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [XLEN-1:0]   rs_data,
  output logic [XLEN-1:0]   rt_data,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef DECODE_WB_BYPASS_EN
    if (wr_en && (wr_addr != '0) && (wr_addr == rs_addr)) rs_data = wr_data;
    if (wr_en && (wr_addr != '0) && (wr_addr == rt_addr)) rt_data = wr_data;
`endif
  end

endmodule

// File: rtl/decode.sv
// MIPS32-subset decode stage: fetch redirect (combinational) and registered ID/EX payload.
// Optional macro DECODE_WB_BYPASS_EN enables write-back forwarding inside regfile.
module decode
  import cpu_defs_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [XLEN-1:0]    if_id_instruc,
  input  logic [XLEN-1:0]    if_id_nextpc,
  input  logic               ex_if_stall,
  input  logic               wb_id_writereg,
  input  logic [REG_AW-1:0]  wb_id_regdest,
  input  logic [XLEN-1:0]    wb_id_data,
  output logic               id_if_selpcsource,
  output logic [1:0]         id_if_selpctype,
  output logic [XLEN-1:0]    id_if_pcimd2ext,
  output logic [XLEN-1:0]    id_if_rega,
  output logic [XLEN-1:0]    id_if_pcindex,
  output logic [XLEN-1:0]    id_ex_rega,
  output logic [XLEN-1:0]    id_ex_regb,
  output logic [XLEN-1:0]    id_ex_imedext,
  output logic [XLEN-1:0]    id_ex_nextpc,
  output logic [ALUOP_W-1:0] id_ex_aluop,
  output logic [REG_AW-1:0]  id_ex_regdest,
  output logic               id_ex_writereg,
  output logic               id_ex_memread,
  output logic               id_ex_memwrite,
  output logic               id_ex_selalusrc
);

  logic [5:0]        opcode, funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [15:0]       imm16;
  logic [XLEN-1:0]   rs_val, rt_val, imm_sext;

  assign opcode   = if_id_instruc[31:26];
  assign rs       = if_id_instruc[25:21];
  assign rt       = if_id_instruc[20:16];
  assign rd       = if_id_instruc[15:11];
  assign imm16    = if_id_instruc[15:0];
  assign funct    = if_id_instruc[5:0];
  assign imm_sext = sext16(imm16);

  regfile u_regfile (
    .clock   (clock),
    .reset   (reset),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rs_val),
    .rt_data (rt_val),
    .wr_en   (wr_id_we_unused_guard(wb_id_writereg)),
    .wr_addr (wb_id_regdest),
    .wr_data (wb_id_data)
  );

  function automatic logic wr_id_we_unused_guard(input logic we);
    return we;
  endfunction

  id_ex_t            id_ex_d, id_ex_q;
  logic              redirect, illegal, writes;
  logic [REG_AW-1:0] dest;
  selpctype_e        selpctype;

  // Instruction decode: next ID/EX payload plus redirect request.
  always_comb begin
    id_ex_d         = '0;
    id_ex_d.rega    = rs_val;
    id_ex_d.regb    = rt_val;
    id_ex_d.imedext = imm_sext;
    id_ex_d.nextpc  = if_id_nextpc;
    id_ex_d.aluop   = ALU_ADD;
    dest            = '0;
    writes          = 1'b0;
    illegal         = 1'b0;
    redirect        = 1'b0;
    selpctype       = PC_BRANCH;
    case (opcode)
      OP_RTYPE: begin
        dest   = rd;
        writes = 1'b1;
        case (funct)
          FN_ADD:  id_ex_d.aluop = ALU_ADD;
          FN_SUB:  id_ex_d.aluop = ALU_SUB;
          FN_AND:  id_ex_d.aluop = ALU_AND;
          FN_OR:   id_ex_d.aluop = ALU_OR;
          FN_SLT:  id_ex_d.aluop = ALU_SLT;
          FN_SLL:  id_ex_d.aluop = ALU_SLL;
          FN_SRL:  id_ex_d.aluop = ALU_SRL;
          FN_JR: begin
            writes    = 1'b0;
            redirect  = 1'b1;
            selpctype = PC_REG;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_J: begin
        redirect  = 1'b1;
        selpctype = PC_JUMP;
      end
      OP_JAL: begin
        redirect      = 1'b1;
        selpctype     = PC_JUMP;
        dest          = REG_AW'(31);
        writes        = 1'b1;
        id_ex_d.rega  = if_id_nextpc + 32'd8;
        id_ex_d.aluop = ALU_PASSA;
      end
      OP_BEQ: begin
        id_ex_d.aluop = ALU_SUB;
        redirect      = (rs_val == rt_val);
      end
      OP_BNE: begin
        id_ex_d.aluop = ALU_SUB;
        redirect      = (rs_val != rt_val);
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
        dest              = rt;
        writes            = 1'b1;
        id_ex_d.selalusrc = 1'b1;
        case (opcode)
          OP_ANDI: begin
            id_ex_d.aluop   = ALU_AND;
            id_ex_d.imedext = {16'h0000, imm16};
          end
          OP_ORI: begin
            id_ex_d.aluop   = ALU_OR;
            id_ex_d.imedext = {16'h0000, imm16};
          end
          OP_LUI: begin
            id_ex_d.aluop   = ALU_PASSB;
            id_ex_d.imedext = {imm16, 16'h0000};
          end
          OP_LW:   id_ex_d.memread = 1'b1;
          default: id_ex_d.aluop = ALU_ADD;
        endcase
      end
      OP_SW: begin
        id_ex_d.memwrite  = 1'b1;
        id_ex_d.selalusrc = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      id_ex_d   = '0;
      redirect  = 1'b1;
      selpctype = PC_EXCEPT;
    end else begin
      // Writes to $0 (including the all-zero NOP) never reach write-back.
      id_ex_d.writereg = writes && (dest != '0);
      id_ex_d.regdest  = id_ex_d.writereg ? dest : '0;
    end
  end

  assign id_if_selpcsource = redirect & ~ex_if_stall;
  assign id_if_selpctype   = selpctype;
  assign id_if_pcimd2ext   = if_id_nextpc + 32'd4 + {imm_sext[29:0], 2'b00};
  assign id_if_rega        = rs_val;
  assign id_if_pcindex     = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};

  always_ff @(posedge clock) begin
    if (reset)             id_ex_q <= '0;
    else if (!ex_if_stall) id_ex_q <= id_ex_d;
  end

  assign id_ex_rega      = id_ex_q.rega;
  assign id_ex_regb      = id_ex_q.regb;
  assign id_ex_imedext   = id_ex_q.imedext;
  assign id_ex_nextpc    = id_ex_q.nextpc;
  assign id_ex_aluop     = id_ex_q.aluop;
  assign id_ex_regdest   = id_ex_q.regdest;
  assign id_ex_writereg  = id_ex_q.writereg;
  assign id_ex_memread   = id_ex_q.memread;
  assign id_ex_memwrite  = id_ex_q.memwrite;
  assign id_ex_selalusrc = id_ex_q.selalusrc;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: expected ID/EX payloads queued at drive time, compared one cycle later.
module tb_decode;
  import cpu_defs_pkg::*;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] if_id_instruc, if_id_nextpc;
  logic        ex_if_stall;
  logic        wb_id_writereg;
  logic [4:0]  wb_id_regdest;
  logic [31:0] wb_id_data;
  logic        id_if_selpcsource;
  logic [1:0]  id_if_selpctype;
  logic [31:0] id_if_pcimd2ext, id_if_rega, id_if_pcindex;
  logic [31:0] id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_nextpc;
  logic [3:0]  id_ex_aluop;
  logic [4:0]  id_ex_regdest;
  logic        id_ex_writereg, id_ex_memread, id_ex_memwrite, id_ex_selalusrc;

  int     vectors = 0;
  int     miscompares = 0;
  id_ex_t sb[$];
  id_ex_t exp_v, held;
  id_ex_t obs;

  always #5 clock = ~clock;

  decode dut (
    .clock(clock), .reset(reset), .if_id_instruc(if_id_instruc), .if_id_nextpc(if_id_nextpc),
    .ex_if_stall(ex_if_stall), .wb_id_writereg(wb_id_writereg), .wb_id_regdest(wb_id_regdest),
    .wb_id_data(wb_id_data), .id_if_selpcsource(id_if_selpcsource), .id_if_selpctype(id_if_selpctype),
    .id_if_pcimd2ext(id_if_pcimd2ext), .id_if_rega(id_if_rega), .id_if_pcindex(id_if_pcindex),
    .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb), .id_ex_imedext(id_ex_imedext),
    .id_ex_nextpc(id_ex_nextpc), .id_ex_aluop(id_ex_aluop), .id_ex_regdest(id_ex_regdest),
    .id_ex_writereg(id_ex_writereg), .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite),
    .id_ex_selalusrc(id_ex_selalusrc)
  );

  assign obs = '{rega: id_ex_rega, regb: id_ex_regb, imedext: id_ex_imedext, nextpc: id_ex_nextpc,
                 aluop: id_ex_aluop, regdest: id_ex_regdest, writereg: id_ex_writereg,
                 memread: id_ex_memread, memwrite: id_ex_memwrite, selalusrc: id_ex_selalusrc};

  function automatic id_ex_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [3:0] op, input logic [4:0] rd,
                                input logic wr, input logic mr, input logic mw, input logic src);
    id_ex_t e;
    e = '{rega: a, regb: b, imedext: imm, nextpc: pc, aluop: op, regdest: rd,
          writereg: wr, memread: mr, memwrite: mw, selalusrc: src};
    return e;
  endfunction

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    if_id_instruc = ins;
    if_id_nextpc  = pc;
  endtask

  task automatic wb(input logic en, input logic [4:0] idx, input logic [31:0] d);
    wb_id_writereg = en;
    wb_id_regdest  = idx;
    wb_id_data     = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_if_stall = 1'b0; wb(1'b0, 5'd0, 32'd0); drive(32'h00A51820, 32'h10);
    sb.push_back('0);
    cycle(); cycle();
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL reset_idex got=%h exp=%h", obs, exp_v); miscompares++; end
    reset = 1'b0;
    drive(32'h20040005, 32'h20); wb(1'b1, 5'd5, 32'h55);
    sb.push_back(mk(32'h0, 32'h0, 32'h5, 32'h20, ALU_ADD, 5'd4, 1, 0, 0, 1));
    cycle(); wb(1'b0, 5'd0, 32'd0);
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL addi_idex got=%h exp=%h", obs, exp_v); miscompares++; end
    // reset together with stall and a pending jump
    reset = 1'b1; ex_if_stall = 1'b1; drive(32'h08000040, 32'h8000_0000);
    #1; vectors++;
    if (id_if_selpcsource !== 1'b0 || id_if_pcindex !== 32'h8000_0100) begin
      $display("FAIL reset_stall_redirect got=%b/%h exp=0/80000100", id_if_selpcsource, id_if_pcindex); miscompares++;
    end
    sb.push_back('0);
    cycle();
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL reset_over_stall got=%h exp=%h", obs, exp_v); miscompares++; end
    ex_if_stall = 1'b0; #1; vectors++;
    if (id_if_selpcsource !== 1'b1 || id_if_selpctype !== 2'b10) begin
      $display("FAIL reset_redirect got=%b/%b exp=1/10", id_if_selpcsource, id_if_selpctype); miscompares++;
    end
    cycle(); reset = 1'b0;
    drive(32'h00A51820, 32'h44);
    sb.push_back(mk(32'h0, 32'h0, 32'h1820, 32'h44, ALU_ADD, 5'd3, 1, 0, 0, 0));
    cycle();
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL regfile_cleared got=%h exp=%h", obs, exp_v); miscompares++; end
  endtask

  task automatic test_add();
    reset = 1'b1; cycle(); reset = 1'b0;
    wb(1'b1, 5'd5, 32'h10); drive(32'h0, 32'h44);
    sb.push_back(mk(32'h0, 32'h0, 32'h0, 32'h44, ALU_SLL, 5'd0, 0, 0, 0, 0));
    cycle(); wb(1'b0, 5'd0, 32'd0);
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL nop_idex got=%h exp=%h", obs, exp_v); miscompares++; end
    drive(32'h00A51820, 32'h48);
    sb.push_back(mk(32'h10, 32'h10, 32'h1820, 32'h48, ALU_ADD, 5'd3, 1, 0, 0, 0));
    cycle();
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL add_idex got=%h exp=%h", obs, exp_v); miscompares++; end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [11];
    id_ex_t      ex  [11];
    ins[0]  = 32'h00A03022; ex[0]  = mk(32'h10, 32'h0,  32'h3022,     0, ALU_SUB,   5'd6,  1, 0, 0, 0);
    ins[1]  = 32'h00A53824; ex[1]  = mk(32'h10, 32'h10, 32'h3824,     0, ALU_AND,   5'd7,  1, 0, 0, 0);
    ins[2]  = 32'h00A04025; ex[2]  = mk(32'h10, 32'h0,  32'h4025,     0, ALU_OR,    5'd8,  1, 0, 0, 0);
    ins[3]  = 32'h0005482A; ex[3]  = mk(32'h0,  32'h10, 32'h482A,     0, ALU_SLT,   5'd9,  1, 0, 0, 0);
    ins[4]  = 32'h00055100; ex[4]  = mk(32'h0,  32'h10, 32'h5100,     0, ALU_SLL,   5'd10, 1, 0, 0, 0);
    ins[5]  = 32'h00055882; ex[5]  = mk(32'h0,  32'h10, 32'h5882,     0, ALU_SRL,   5'd11, 1, 0, 0, 0);
    ins[6]  = 32'h20A48000; ex[6]  = mk(32'h10, 32'h0,  32'hFFFF8000, 0, ALU_ADD,   5'd4,  1, 0, 0, 1);
    ins[7]  = 32'h30A38000; ex[7]  = mk(32'h10, 32'h0,  32'h00008000, 0, ALU_AND,   5'd3,  1, 0, 0, 1);
    ins[8]  = 32'h3C0C1234; ex[8]  = mk(32'h0,  32'h0,  32'h12340000, 0, ALU_PASSB, 5'd12, 1, 0, 0, 1);
    ins[9]  = 32'hAC050008; ex[9]  = mk(32'h0,  32'h10, 32'h8,        0, ALU_ADD,   5'd0,  0, 0, 1, 1);
    ins[10] = 32'h00A50020; ex[10] = mk(32'h10, 32'h10, 32'h20,       0, ALU_ADD,   5'd0,  0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      ex[i].nextpc = 32'h200 + 32'(i * 4);
      drive(ins[i], ex[i].nextpc);
      sb.push_back(ex[i]);
      #1; vectors++;
      if (id_if_selpcsource !== 1'b0) begin
        $display("FAIL b2b_noredirect[%0d] got=%b exp=0", i, id_if_selpcsource); miscompares++;
      end
      cycle();
      exp_v = sb.pop_front(); vectors++;
      if (obs !== exp_v) begin $display("FAIL b2b_idex[%0d] got=%h exp=%h", i, obs, exp_v); miscompares++; end
    end
  endtask

  task automatic test_branch();
    drive(32'h10210003, 32'h100); #1; vectors++;
    if (id_if_selpcsource !== 1'b1 || id_if_selpctype !== 2'b00 || id_if_pcimd2ext !== 32'h110) begin
      $display("FAIL beq_taken got=%b/%b/%h exp=1/00/00000110", id_if_selpcsource, id_if_selpctype, id_if_pcimd2ext); miscompares++;
    end
    sb.push_back(mk(32'h0, 32'h0, 32'h3, 32'h100, ALU_SUB, 5'd0, 0, 0, 0, 0));
    cycle();
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL beq_idex got=%h exp=%h", obs, exp_v); miscompares++; end
    drive(32'h14210003, 32'h100); #1; vectors++;
    if (id_if_selpcsource !== 1'b0) begin $display("FAIL bne_not_taken got=%b exp=0", id_if_selpcsource); miscompares++; end
    drive(32'h10000001, 32'hFFFF_FFFC); #1; vectors++;
    if (id_if_selpcsource !== 1'b1 || id_if_pcimd2ext !== 32'h4) begin
      $display("FAIL beq_wrap got=%b/%h exp=1/00000004", id_if_selpcsource, id_if_pcimd2ext); miscompares++;
    end
    drive(32'h1000FFFF, 32'h100); #1; vectors++;
    if (id_if_pcimd2ext !== 32'h100) begin $display("FAIL beq_negative got=%h exp=00000100", id_if_pcimd2ext); miscompares++; end
    drive(32'h14A00002, 32'h100); #1; vectors++;
    if (id_if_selpcsource !== 1'b1 || id_if_pcimd2ext !== 32'h10C) begin
      $display("FAIL bne_taken got=%b/%h exp=1/0000010c", id_if_selpcsource, id_if_pcimd2ext); miscompares++;
    end
    cycle();
    // delay slot after a taken branch decodes normally
    drive(32'h00A04025, 32'h104);
    sb.push_back(mk(32'h10, 32'h0, 32'h4025, 32'h104, ALU_OR, 5'd8, 1, 0, 0, 0));
    cycle();
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL delay_slot_idex got=%h exp=%h", obs, exp_v); miscompares++; end
  endtask

  task automatic test_jump();
    drive(32'h08000040, 32'h8000_0000); #1; vectors++;
    if (id_if_selpcsource !== 1'b1 || id_if_selpctype !== 2'b10 || id_if_pcindex !== 32'h8000_0100) begin
      $display("FAIL j_redirect got=%b/%b/%h exp=1/10/80000100", id_if_selpcsource, id_if_selpctype, id_if_pcindex); miscompares++;
    end
    sb.push_back(mk(32'h0, 32'h0, 32'h40, 32'h8000_0000, ALU_ADD, 5'd0, 0, 0, 0, 0));
    cycle();
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL j_idex got=%h exp=%h", obs, exp_v); miscompares++; end
    drive(32'h0C000040, 32'h8000_0000);
    sb.push_back(mk(32'h8000_0008, 32'h0, 32'h40, 32'h8000_0000, ALU_PASSA, 5'd31, 1, 0, 0, 0));
    cycle();
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL jal_idex got=%h exp=%h", obs, exp_v); miscompares++; end
    drive(32'h0C000040, 32'hFFFF_FFF8); #1; vectors++;
    if (id_if_pcindex !== 32'hF000_0100) begin $display("FAIL jal_hi_pcindex got=%h exp=f0000100", id_if_pcindex); miscompares++; end
    sb.push_back(mk(32'h0, 32'h0, 32'h40, 32'hFFFF_FFF8, ALU_PASSA, 5'd31, 1, 0, 0, 0));
    cycle();
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL jal_wrap_idex got=%h exp=%h", obs, exp_v); miscompares++; end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bad[0] = 32'hFC000000; bad[1] = 32'h00000001;
    for (int i = 0; i < 2; i++) begin
      drive(bad[i], 32'h300); #1; vectors++;
      if (id_if_selpcsource !== 1'b1 || id_if_selpctype !== 2'b11) begin
        $display("FAIL illegal_redirect[%0d] got=%b/%b exp=1/11", i, id_if_selpcsource, id_if_selpctype); miscompares++;
      end
      sb.push_back('0);
      cycle();
      exp_v = sb.pop_front(); vectors++;
      if (obs !== exp_v) begin $display("FAIL illegal_bubble[%0d] got=%h exp=%h", i, obs, exp_v); miscompares++; end
    end
  endtask

  task automatic test_wb_bypass();
    logic [31:0] v;
    wb(1'b1, 5'd7, 32'h1111_1111); drive(32'h0, 32'h3FC); cycle();
    wb(1'b1, 5'd7, 32'hDEAD_BEEF); drive(32'h00E00008, 32'h400);
    v = BYP ? 32'hDEAD_BEEF : 32'h1111_1111;
    #1; vectors++;
    if (id_if_rega !== v || id_if_selpctype !== 2'b01 || id_if_selpcsource !== 1'b1) begin
      $display("FAIL jr_rega got=%h/%b/%b exp=%h/01/1", id_if_rega, id_if_selpctype, id_if_selpcsource, v); miscompares++;
    end
    sb.push_back(mk(v, 32'h0, 32'h8, 32'h400, ALU_ADD, 5'd0, 0, 0, 0, 0));
    cycle(); wb(1'b0, 5'd0, 32'd0);
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL jr_idex got=%h exp=%h", obs, exp_v); miscompares++; end
    drive(32'h00E04020, 32'h404);
    sb.push_back(mk(32'hDEAD_BEEF, 32'h0, 32'h4020, 32'h404, ALU_ADD, 5'd8, 1, 0, 0, 0));
    cycle();
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL wb_visible_idex got=%h exp=%h", obs, exp_v); miscompares++; end
    wb(1'b1, 5'd0, 32'hFFFF); drive(32'h00004820, 32'h408);
    sb.push_back(mk(32'h0, 32'h0, 32'h4820, 32'h408, ALU_ADD, 5'd9, 1, 0, 0, 0));
    cycle(); wb(1'b0, 5'd0, 32'd0);
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL r0_write_idex got=%h exp=%h", obs, exp_v); miscompares++; end
    wb(1'b1, 5'd13, 32'h5); drive(32'h11A00001, 32'h40C); #1; vectors++;
    if (id_if_selpcsource !== !BYP) begin
      $display("FAIL beq_bypass got=%b exp=%b", id_if_selpcsource, !BYP); miscompares++;
    end
    cycle(); wb(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_stall();
    drive(32'h8CA60004, 32'h500);
    sb.push_back(mk(32'h10, 32'h0, 32'h4, 32'h500, ALU_ADD, 5'd6, 1, 1, 0, 1));
    cycle();
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL lw_idex got=%h exp=%h", obs, exp_v); miscompares++; end
    held = exp_v;
    ex_if_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h10000001, 32'h504);
      if (i == 0) wb(1'b1, 5'd14, 32'h77); else wb(1'b0, 5'd0, 32'd0);
      #1; vectors++;
      if (id_if_selpcsource !== 1'b0) begin
        $display("FAIL stall_redirect[%0d] got=%b exp=0", i, id_if_selpcsource); miscompares++;
      end
      cycle(); vectors++;
      if (obs !== held) begin $display("FAIL stall_hold[%0d] got=%h exp=%h", i, obs, held); miscompares++; end
    end
    ex_if_stall = 1'b0; wb(1'b0, 5'd0, 32'd0);
    drive(32'h3402FFFF, 32'h504);
    sb.push_back(mk(32'h0, 32'h0, 32'h0000_FFFF, 32'h504, ALU_OR, 5'd2, 1, 0, 0, 1));
    cycle();
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL ori_idex got=%h exp=%h", obs, exp_v); miscompares++; end
    drive(32'h01C07820, 32'h508);
    sb.push_back(mk(32'h77, 32'h0, 32'h7820, 32'h508, ALU_ADD, 5'd15, 1, 0, 0, 0));
    cycle();
    exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin $display("FAIL stall_wb_idex got=%h exp=%h", obs, exp_v); miscompares++; end
  endtask

  initial begin
    reset = 1'b1; ex_if_stall = 1'b0;
    if_id_instruc = 32'h0; if_id_nextpc = 32'h0;
    wb_id_writereg = 1'b0; wb_id_regdest = 5'd0; wb_id_data = 32'h0;
    @(negedge clock);
    test_reset();
    test_add();
    test_back_to_back();
    test_branch();
    test_jump();
    test_illegal();
    test_wb_bypass();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high.
REQ-003 SHALL have: if_id_instruc  in  32  instruction from fetch; if_id_nextpc  in  32  PC of that instruction.
REQ-004 SHALL have: ex_if_stall  in  1  execute stall request.
REQ-005 SHALL have: wb_id_writereg  in  1  write enable; wb_id_regdest  in  5  write index; wb_id_data  in  32  write data.
REQ-006 SHALL have: id_if_selpcsource  out  1  redirect fetch; id_if_selpctype  out  2  00 branch, 01 register, 10 jump index, 11 exception vector; id_if_pcimd2ext, id_if_rega, id_if_pcindex  out  32 each  redirect targets.
REQ-007 SHALL have: id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_nextpc  out  32; id_ex_aluop  out  4; id_ex_regdest  out  5; id_ex_writereg, id_ex_memread, id_ex_memwrite, id_ex_selalusrc  out  1.

Function
REQ-008 SHALL decode MIPS32 subset: R-type ADD, SUB, AND, OR, SLT, SLL, SRL, JR; ADDI, ANDI, ORI, LUI, LW, SW, BEQ, BNE, J, JAL.
REQ-009 SHALL contain a 32x32 register file; register 0 reads 0, writes to it ignored; write on rising edge when wb_id_writereg=1.
REQ-010 SHALL drive id_if_* combinationally from if_id_instruc in the same cycle.
REQ-011 BEQ/BNE: compare rs,rt read values; taken -> selpcsource=1, selpctype=00, pcimd2ext = nextpc + 4 + (sext(imm16) << 2), 32-bit wrap.
REQ-012 J/JAL: selpcsource=1, selpctype=10, pcindex = {nextpc[31:28], instr[25:0], 2'b00}; JR: selpctype=01, rega = rs value.
REQ-013 Undefined opcode/funct: selpcsource=1, selpctype=11; ID/EX loads bubble.
REQ-014 One architectural delay slot; decode never flushes the instruction following a branch.
REQ-015 ID/EX outputs registered: one cycle latency from if_id_instruc.
REQ-016 imedext: sign-extend for ADDI/LW/SW/BEQ/BNE; zero-extend for ANDI/ORI; imm16<<16 for LUI.
REQ-017 regdest: rd for R-type, rt for I-type loads/ALU, 31 for JAL (rega=nextpc+8, aluop pass-A); writereg=0 for SW, branches, J, JR.
REQ-018 Instruction 0x00000000 (NOP) SHALL decode as SLL $0 with writereg=0.
REQ-019 ex_if_stall=1: ID/EX registers hold, selpcsource forced 0; register file writes still occur.
REQ-020 Simultaneous ex_if_stall and reset: reset wins.

Reset
REQ-021 reset=1 at a rising edge SHALL clear all ID/EX outputs to 0 and all 32 registers to 0.
REQ-022 Reset mid-redirect: id_if_* outputs follow if_id_instruc; no state retained across reset.

Configuration
REQ-023 Macro DECODE_WB_BYPASS_EN defined: read of register equal to wb_id_regdest with wb_id_writereg=1 (nonzero index) SHALL return wb_id_data same cycle, including branch compare and JR.
REQ-024 Macro undefined: reads return pre-write value; writer's result visible next cycle.

Structure
REQ-025 Opcode, funct and aluop constants and selpctype encodings SHALL live in shared package cpu_defs_pkg.
REQ-026 Register file SHALL be sub-module regfile (2 read ports, 1 write port, macro-controlled bypass).

Verification
REQ-027 Reset, then write $5=0x0000_0010 via WB, decode ADD $3,$5,$5 -> next cycle id_ex_rega=regb=0x10, regdest=3, writereg=1.
REQ-028 nextpc=0x100, BEQ $1,$1,+3 -> selpcsource=1, selpctype=00, pcimd2ext=0x110; BNE same -> selpcsource=0.
REQ-029 nextpc=0x8000_0000, J 0x0000040 -> pcindex=0x8000_0100; JAL -> regdest=31, rega=0x8000_0008.
REQ-030 Opcode 0x3F -> selpctype=11, next ID/EX writereg=memread=memwrite=0.
REQ-031 WB writes $7=0xDEAD_BEEF while JR $7 decodes -> id_if_rega=0xDEADBEEF with DECODE_WB_BYPASS_EN, old value without.
REQ-032 ex_if_stall=1 for 3 cycles during LW -> ID/EX outputs unchanged; ORI $2,$0,0xFFFF -> imedext=0x0000FFFF.
